mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified single-port memory between the pipeline's IF stage (instruction fetch)
//  and MEM stage (load/store). Arbitrates requests and sequences each access with a ready-based
//  wait-state handshake. Returns read data and per-stage stall signals to the pipeline.
//  Detects hung memory accesses with a timeout.
// PARAMETERS
//  AW          32   address width
//  DW          32   data width; byte-enable width is DW/8
//  MAX_DM_RUN  4    max consecutive MEM grants while if_req is pending (fetch anti-starvation)
//  TIMEOUT     64   cycles in a busy state without mem_ready before the access is aborted
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     synchronous, active-high
//  if_req     in   1     fetch request; held high until if_ack
//  if_addr    in   AW    fetch address; stable while if_req is high
//  if_rdata   out  DW    fetch data
//  if_ack     out  1     one-cycle pulse; fetch complete
//  dm_req     in   1     data request; held high until dm_ack
//  dm_we      in   1     1 = store, 0 = load
//  dm_addr    in   AW    data address
//  dm_wdata   in   DW    store data
//  dm_be      in   DW/8  store byte enables
//  dm_rdata   out  DW    load data
//  dm_ack     out  1     one-cycle pulse; data access complete
//  mem_req    out  1     memory access in progress
//  mem_we     out  1     memory write strobe; valid while mem_req is high
//  mem_addr   out  AW    memory address (registered)
//  mem_wdata  out  DW    memory write data (registered)
//  mem_be     out  DW/8  memory byte enables (registered; all ones for fetch and load)
//  mem_rdata  in   DW    memory read data; valid when mem_ready is high
//  mem_ready  in   1     memory completes the current access this cycle
//  stall_if   out  1     if_req & ~if_ack (combinational)
//  stall_mem  out  1     dm_req & ~dm_ack (combinational)
//  err        out  1     sticky timeout flag
// BEHAVIOUR
//  Reset values: state = IDLE; all registered outputs = 0; run and timeout counters = 0; err = 0.
//  States:
//   - IDLE: grant is decided at the clock edge.
//     - DM wins if dm_req is high and run < MAX_DM_RUN.
//     - Otherwise IF wins if if_req is high.
//     - Otherwise DM wins if dm_req is high.
//     - On grant: latch addr, wdata, be and we into the mem_* registers, set mem_req = 1,
//       and go to BUSY_IF or BUSY_DM.
//   - BUSY_x: mem_req = 1 and mem_* are held stable.
//     - On mem_ready, x_ack = 1 combinationally in that same cycle. At the edge, go to IDLE,
//       drop mem_req and clear the timeout counter.
//  Latency: the minimum access is 2 cycles (request seen in IDLE at cycle N, mem_ready at N+1,
//   ack at N+1). There is always exactly one IDLE cycle between accesses.
//  Read data:
//   - During an ack cycle, x_rdata = mem_rdata.
//   - Otherwise x_rdata holds the value of its last read ack.
//   - Store acks do not update dm_rdata.
//  Run counter:
//   - Increments on each DM grant made while if_req is high.
//   - Clears on any IF grant and on any cycle where if_req is low.
//   - Saturates at MAX_DM_RUN.
//  Timeout:
//   - The counter increments each BUSY cycle in which mem_ready is low.
//   - When it reaches TIMEOUT-1 with mem_ready still low:
//     - x_ack is pulsed with x_rdata = 0.
//     - err is set; it stays set until reset.
//     - The FSM returns to IDLE.
//  mem_ready while IDLE is ignored; this includes a late response after reset or after a timeout.
//  A request deasserted while BUSY (protocol violation) does not abort the access; the ack is
//   still generated.
//  Reset mid-access: mem_req is low from the cycle after the reset edge, and no ack is issued.
// TESTING
//  T1 if_req=1, if_addr=0x0000_0040, mem_ready tied to 1
//     -> mem_req/mem_addr=0x40 at N+1; if_ack and if_rdata=mem_rdata at N+1; stall_if=1 at N only.
//  T2 if_req and dm_req (load, 0x100) both rise at once
//     -> DM granted first; IF granted after the IDLE gap; exactly one ack each.
//  T3 dm_req held for 6 back-to-back stores while if_req=1
//     -> IF is granted after the 4th DM access; DM then resumes.
//  T4 load to 0x200 with mem_ready low for 3 cycles and mem_rdata=0xCAFE_F00D
//     -> mem_addr is stable for 4 cycles; dm_ack and dm_rdata=0xCAFE_F00D on the 4th cycle.
//  T5 mem_ready held low for 64 cycles
//     -> dm_ack with dm_rdata=0 and err=1; a later mem_ready pulse in IDLE has no effect.
//  T6 reset asserted during BUSY_DM
//     -> next cycle mem_req=0 and state IDLE; no dm_ack; all outputs at their reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and load/store (DM). Sequences each access with a mem_ready wait-state handshake,
// returns read data and stage stalls, and aborts hung accesses with a timeout.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam int RW = $clog2(MAX_DM_RUN + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_DM = 2'd2;

  logic [1:0]    state;
  logic [RW-1:0] run;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  logic          busy;
  logic          tmo;
  logic          done;
  logic          grant_dm;
  logic          grant_if;
  logic [DW-1:0] resp;

  // Grant decision, access completion and timeout detection.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    busy     = (state != S_IDLE);
    tmo      = busy && !mem_ready && (tcnt == TW'(TIMEOUT - 1));
    // An access caught by reset never completes, so it never acks.
    done     = busy && !reset && (mem_ready || tmo);
    // DM has priority until it has used up its run while a fetch waits.
    grant_dm = (state == S_IDLE) && dm_req && ((run < RW'(MAX_DM_RUN)) || !if_req);
    grant_if = (state == S_IDLE) && if_req && !grant_dm;
    resp     = tmo ? '0 : mem_rdata;
  end

  assign mem_req   = busy;
  assign if_ack    = done && (state == S_BUSY_IF);
  assign dm_ack    = done && (state == S_BUSY_DM);
  assign if_rdata  = if_ack ? resp : if_rdata_q;
  assign dm_rdata  = (dm_ack && !mem_we) ? resp : dm_rdata_q;
  assign stall_if  = if_req && !if_ack;
  assign stall_mem = dm_req && !dm_ack;

  // Access FSM and the registered memory-side request fields.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_dm) begin
            state     <= S_BUSY_DM;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_we ? dm_be : {BW{1'b1}};
          end else if (grant_if) begin
            state     <= S_BUSY_IF;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= {BW{1'b1}};
          end
        end
        S_BUSY_IF, S_BUSY_DM: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fetch anti-starvation run counter and the hung-access timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      run  <= '0;
      tcnt <= '0;
    end else begin
      if (!if_req || grant_if) run <= '0;
      else if (grant_dm && (run < RW'(MAX_DM_RUN))) run <= run + RW'(1);

      if (!busy || done) tcnt <= '0;
      else if (!mem_ready) tcnt <= tcnt + TW'(1);
    end
  end

  // Read-data holding registers and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err        <= 1'b0;
    end else begin
      if (if_ack) if_rdata_q <= resp;
      if (dm_ack && !mem_we) dm_rdata_q <= resp;
      if (done && tmo) err <= 1'b1;
    end
  end

endmodule
